// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255-style PPI bus master: controller states,
// PPI register addresses, control-word bit positions and phase counter width.
package ppi_pkg;

    // Width of the shared phase / init down-counter (parameters go up to 15)
    localparam int CNT_W = 4;

    // Controller states, in the order a transaction walks through them
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } ppi_state_e;

    // PPI register select values presented on A[1:0]
    localparam logic [1:0] PORT_A    = 2'b00;
    localparam logic [1:0] PORT_B    = 2'b01;
    localparam logic [1:0] PORT_C    = 2'b10;
    localparam logic [1:0] CTRL_WORD = 2'b11;

    // Control-word field positions
    localparam int CW_MODE_SET_BIT = 7;
    localparam int CW_PB_MODE_BIT  = 2;
    localparam int CW_PB_DIR_BIT   = 1;

    // True for the states in which the chip is selected and A is presented
    function automatic logic isBusPhase(input ppi_state_e s);
        return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// Loadable down-counter shared by the init wait and every bus phase.
// It stops at zero; o_tc is high while the count is zero, so a phase loaded
// with N-1 lasts exactly N cycles.
module ppi_phase_timer
    import ppi_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Load a new phase length, otherwise count down and park at zero
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// Request/response front end that runs timed read/write cycles on an
// 8255-style PPI bus. All outputs except PD come straight from flops that are
// loaded from the next-state decode, so the bus pins change cleanly on the
// clock edge that enters each phase.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 2,
    parameter int T_HOLD   = 1,
    parameter int RST_CYC  = 4
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       nCs,
    output logic       nRd,
    output logic       nWr,
    output logic [1:0] A,
    output logic       ppi_reset,
    inout  wire  [7:0] PD
);

    // Counter reload values: a phase of N cycles is loaded with N-1. The init
    // wait is loaded with RST_CYC itself because the first INIT cycle is the
    // partial one in which nReset rises.
    localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_STROBE = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_RST    = CNT_W'(RST_CYC);

    ppi_state_e       r_state;
    ppi_state_e       w_stateNext;
    logic             w_accept;
    logic             w_load;
    logic [CNT_W-1:0] w_loadVal;
    logic             w_tc;
    logic             w_wrNext;

    logic             r_wr;
    logic [1:0]       r_addr;
    logic [7:0]       r_wdata;
    logic             r_nCs;
    logic             r_nRd;
    logic             r_nWr;
    logic             r_pdOe;
    logic             r_reqReady;
    logic             r_rspValid;
    logic [7:0]       r_rspData;
    logic             r_ppiReset;

    ppi_phase_timer #(
        .RESET_VAL (L_RST)
    ) u_phaseTimer (
        .clk       (clk),
        .nReset    (nReset),
        .i_load    (w_load),
        .i_loadVal (w_loadVal),
        .o_tc      (w_tc)
    );

    // r_reqReady is only ever set while the next state is IDLE
    assign w_accept = req_valid && r_reqReady && (r_state == ST_IDLE);

    // On the accepting edge the latched direction is not yet valid
    assign w_wrNext = w_accept ? req_wr : r_wr;

    // Phase sequencing; each transition into a bus phase reloads the counter
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_loadVal   = '0;
        case (r_state)
            ST_INIT: begin
                if (w_tc) begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_accept) begin
                    w_stateNext = ST_SETUP;
                    w_load      = 1'b1;
                    w_loadVal   = L_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tc) begin
                    w_stateNext = ST_STROBE;
                    w_load      = 1'b1;
                    w_loadVal   = L_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_tc) begin
                    w_stateNext = ST_HOLD;
                    w_load      = 1'b1;
                    w_loadVal   = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_tc) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_INIT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Capture the request so later input changes cannot disturb the cycle
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_wr    <= 1'b0;
            r_addr  <= 2'b00;
            r_wdata <= 8'h00;
        end else if (w_accept) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Bus pins decoded from the state being entered; strobes are exclusive
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_nCs  <= 1'b1;
            r_nRd  <= 1'b1;
            r_nWr  <= 1'b1;
            r_pdOe <= 1'b0;
        end else begin
            r_nCs  <= !isBusPhase(w_stateNext);
            r_nWr  <= !((w_stateNext == ST_STROBE) && w_wrNext);
            r_nRd  <= !((w_stateNext == ST_STROBE) && !w_wrNext);
            r_pdOe <= isBusPhase(w_stateNext) && w_wrNext;
        end
    end

    // Handshake, PPI reset and read-data capture at the end of the strobe
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_reqReady <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspData  <= 8'h00;
            r_ppiReset <= 1'b1;
        end else begin
            r_reqReady <= (w_stateNext == ST_IDLE) && (r_state != ST_INIT);
            r_rspValid <= (r_state == ST_HOLD) && w_tc;
            r_ppiReset <= (w_stateNext == ST_INIT);
            if ((r_state == ST_STROBE) && w_tc && !r_wr) begin
                r_rspData <= PD;
            end
        end
    end

    assign PD        = r_pdOe ? r_wdata : 8'hzz;
    assign nCs       = r_nCs;
    assign nRd       = r_nRd;
    assign nWr       = r_nWr;
    assign A         = r_addr;
    assign req_ready = r_reqReady;
    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign ppi_reset = r_ppiReset;

endmodule
